store_merge_unit: RTL and testbench

Memory-side store path for the MIPS datapath: the narrowing counterpart of the load/immediate sign extender. Accepts sw/sh/sb requests from the MEM stage, checks alignment, and writes to a word-only data memory with no byte enables. Byte and halfword stores use a read-modify-write sequence that splices the low 8/16 bits of the register into the addressed lane. Misaligned or illegal stores are rejected without touching memory.

---
 rtl/store_merge_unit.sv | 132 +++++++++++++
 tb/tb_store_merge_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/store_merge_unit.sv
// store_merge_unit
// Store path for a word-only data memory (no byte enables).
// sw goes straight to memory. sb and sh use read-modify-write: the word is
// read, the addressed little-endian lane is replaced with the low 8/16 bits
// of the register, and the merged word is written back.
// Misaligned or illegal stores are rejected with a misalign pulse and never
// touch memory.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready request handshake; ready only in IDLE
//   req_addr[31:0]      byte address
//   req_data[31:0]      register value
//   req_size[1:0]       00 byte, 01 half, 10 word, 11 illegal
//   done, misalign      one-cycle completion / reject pulses
//   mem_addr[31:0]      word-aligned memory address
//   mem_rd, mem_wr      one-cycle read / write strobes
//   mem_rdata, mem_rvalid  read return, any latency >= 1
//   mem_wdata[31:0]     full word to write
//
// state | meaning
// IDLE  | ready for a request
// READ  | mem_rd strobe for a sub-word store
// WAIT  | waiting for mem_rvalid; merge is captured on rvalid
// WRITE | mem_wr strobe and done pulse
// ERR   | misalign pulse, no memory access
module store_merge_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_data,
   input  logic [1:0]  req_size,
   output logic        done,
   output logic        misalign,
   output logic [31:0] mem_addr,
   output logic        mem_rd,
   input  logic [31:0] mem_rdata,
   input  logic        mem_rvalid,
   output logic        mem_wr,
   output logic [31:0] mem_wdata
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_WAIT  = 3'd2,
      S_WRITE = 3'd3,
      S_ERR   = 3'd4
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic        accept;
   logic [1:0]  lane_q;
   logic        half_q;
   logic [15:0] data_q;
   logic [31:0] merged;

   assign req_ready = (state == S_IDLE);
   assign accept    = req_valid && req_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (req_valid) begin
               case (req_size)
                  2'b00:   state_nxt = S_READ;
                  2'b01:   state_nxt = req_addr[0] ? S_ERR : S_READ;
                  2'b10:   state_nxt = (req_addr[1:0] == 2'b00) ? S_WRITE : S_ERR;
                  default: state_nxt = S_ERR;
               endcase
            end
         end
         S_READ:  state_nxt = S_WAIT;
         S_WAIT:  if (mem_rvalid) state_nxt = S_WRITE;
         S_WRITE: state_nxt = S_IDLE;
         S_ERR:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Replace only the addressed lane of the read word.
   always_comb begin
      merged = mem_rdata;
      if (half_q) begin
         if (lane_q[1]) merged[31:16] = data_q;
         else           merged[15:0]  = data_q;
      end else begin
         merged[{lane_q, 3'b000} +: 8] = data_q[7:0];
      end
   end

   // Strobes are registered from the next state so each is high for
   // exactly the cycle spent in its state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done      <= 1'b0;
         misalign  <= 1'b0;
         mem_rd    <= 1'b0;
         mem_wr    <= 1'b0;
         mem_addr  <= 32'h0;
         mem_wdata <= 32'h0;
         lane_q    <= 2'b00;
         half_q    <= 1'b0;
         data_q    <= 16'h0;
      end else begin
         done     <= (state_nxt == S_WRITE);
         misalign <= (state_nxt == S_ERR);
         mem_rd   <= (state_nxt == S_READ);
         mem_wr   <= (state_nxt == S_WRITE);
         if (accept) begin
            mem_addr <= {req_addr[31:2], 2'b00};
            lane_q   <= req_addr[1:0];
            half_q   <= (req_size == 2'b01);
            data_q   <= req_data[15:0];
         end
         if (state == S_IDLE && state_nxt == S_WRITE)
            mem_wdata <= req_data;
         else if (state == S_WAIT && mem_rvalid)
            mem_wdata <= merged;
      end
   end

endmodule

// File: tb/tb_store_merge_unit.sv
module tb_store_merge_unit;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [31:0] req_data;
   logic [1:0]  req_size;
   logic        done;
   logic        misalign;
   logic [31:0] mem_addr;
   logic        mem_rd;
   logic [31:0] mem_rdata;
   logic        mem_rvalid;
   logic        mem_wr;
   logic [31:0] mem_wdata;

   int n_checks;
   int n_fail;

   store_merge_unit dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_data   (req_data),
      .req_size   (req_size),
      .done       (done),
      .misalign   (misalign),
      .mem_addr   (mem_addr),
      .mem_rd     (mem_rd),
      .mem_rdata  (mem_rdata),
      .mem_rvalid (mem_rvalid),
      .mem_wr     (mem_wr),
      .mem_wdata  (mem_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_addr   = 32'h0;
      req_data   = 32'h0;
      req_size   = 2'b00;
      mem_rdata  = 32'h0;
      mem_rvalid = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      n_checks++;
      if (req_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_ready got %b want 1", req_ready);
      end
      n_checks++;
      if ({done, misalign, mem_rd, mem_wr} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_strobes got %b want 0000", {done, misalign, mem_rd, mem_wr});
      end
      n_checks++;
      if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
         n_fail++; $display("FAIL reset_buses got addr=%h wdata=%h want 0/0", mem_addr, mem_wdata);
      end
   endtask

   task automatic test_word();
      req_valid = 1'b1; req_addr = 32'h0000_0010; req_data = 32'hDEAD_BEEF; req_size = 2'b10;
      tick();
      req_valid = 1'b0;
      n_checks++;
      if ({mem_wr, done, mem_rd, misalign, req_ready} !== 5'b11000) begin
         n_fail++; $display("FAIL sw_strobes got wr,done,rd,mis,rdy=%b want 11000", {mem_wr, done, mem_rd, misalign, req_ready});
      end
      n_checks++;
      if (mem_addr !== 32'h10 || mem_wdata !== 32'hDEAD_BEEF) begin
         n_fail++; $display("FAIL sw_data got addr=%h wdata=%h want 00000010/deadbeef", mem_addr, mem_wdata);
      end
      tick();
      n_checks++;
      if ({req_ready, mem_wr, done, mem_rd} !== 4'b1000) begin
         n_fail++; $display("FAIL sw_return got rdy,wr,done,rd=%b want 1000", {req_ready, mem_wr, done, mem_rd});
      end
   endtask

   // Sub-word store with rvalid arriving after `delay` empty WAIT cycles.
   task automatic sub_store(input string name, input logic [31:0] addr, input logic [1:0] size,
                            input logic [31:0] data, input logic [31:0] rdata,
                            input int delay, input logic [31:0] exp);
      req_valid = 1'b1; req_addr = addr; req_data = data; req_size = size;
      tick();
      req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_data = 32'h0;
      n_checks++;
      if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== {addr[31:2], 2'b00}) begin
         n_fail++; $display("FAIL %s_read got rd=%b wr=%b addr=%h want 1/0/%h", name, mem_rd, mem_wr, mem_addr, {addr[31:2], 2'b00});
      end
      tick();
      for (int i = 0; i < delay; i++) begin
         mem_rdata = 32'h5A5A_5A5A;
         n_checks++;
         if ({req_ready, mem_rd, mem_wr, done} !== 4'b0000) begin
            n_fail++; $display("FAIL %s_wait%0d got rdy,rd,wr,done=%b want 0000", name, i, {req_ready, mem_rd, mem_wr, done});
         end
         tick();
      end
      mem_rvalid = 1'b1; mem_rdata = rdata;
      tick();
      mem_rvalid = 1'b0; mem_rdata = 32'h0;
      n_checks++;
      if ({mem_wr, done, mem_rd} !== 3'b110 || mem_wdata !== exp) begin
         n_fail++; $display("FAIL %s_write got wr,done,rd=%b wdata=%h want 110/%h", name, {mem_wr, done, mem_rd}, mem_wdata, exp);
      end
      tick();
      n_checks++;
      if (req_ready !== 1'b1 || done !== 1'b0 || mem_wr !== 1'b0) begin
         n_fail++; $display("FAIL %s_return got rdy=%b done=%b wr=%b want 1/0/0", name, req_ready, done, mem_wr);
      end
   endtask

   task automatic test_byte();
      sub_store("sb_lane3", 32'h0000_0023, 2'b00, 32'h1234_56AB, 32'h1111_1111, 0, 32'hAB11_1111);
      sub_store("sb_lane1", 32'h0000_0041, 2'b00, 32'hFFFF_FFCD, 32'h1234_5678, 1, 32'h1234_CD78);
      sub_store("sb_lane0", 32'h0000_0100, 2'b00, 32'h0000_0099, 32'hFFFF_FFFF, 0, 32'hFFFF_FF99);
   endtask

   task automatic test_half();
      sub_store("sh_hi_delay", 32'h0000_0006, 2'b01, 32'hFFFF_8001, 32'hAAAA_5555, 4, 32'h8001_5555);
      sub_store("sh_lo", 32'h0000_0008, 2'b01, 32'h0000_BEEF, 32'hCAFE_F00D, 0, 32'hCAFE_BEEF);
   endtask

   task automatic test_misalign();
      logic [31:0] addrs [3];
      logic [1:0]  sizes [3];
      addrs[0] = 32'h0000_0005; sizes[0] = 2'b01;
      addrs[1] = 32'h0000_0002; sizes[1] = 2'b10;
      addrs[2] = 32'h0000_0000; sizes[2] = 2'b11;
      for (int i = 0; i < 3; i++) begin
         req_valid = 1'b1; req_addr = addrs[i]; req_data = 32'h7777_7777; req_size = sizes[i];
         tick();
         req_valid = 1'b0;
         n_checks++;
         if ({misalign, done, mem_rd, mem_wr, req_ready} !== 5'b10000) begin
            n_fail++; $display("FAIL misalign%0d got mis,done,rd,wr,rdy=%b want 10000", i, {misalign, done, mem_rd, mem_wr, req_ready});
         end
         tick();
         n_checks++;
         if ({misalign, req_ready, mem_rd, mem_wr} !== 4'b0100) begin
            n_fail++; $display("FAIL misalign%0d_return got mis,rdy,rd,wr=%b want 0100", i, {misalign, req_ready, mem_rd, mem_wr});
         end
      end
   endtask

   task automatic test_back_to_back();
      int n_done;
      n_done = 0;
      req_valid = 1'b1; req_addr = 32'h0000_0030; req_data = 32'h0102_0304; req_size = 2'b10;
      tick();
      if (done === 1'b1) n_done++;
      n_checks++;
      if (mem_wdata !== 32'h0102_0304 || mem_addr !== 32'h30) begin
         n_fail++; $display("FAIL b2b_first got addr=%h wdata=%h want 00000030/01020304", mem_addr, mem_wdata);
      end
      req_addr = 32'h0000_0034; req_data = 32'hA5A5_0F0F;
      tick();
      if (done === 1'b1) n_done++;
      n_checks++;
      if (req_ready !== 1'b1 || mem_wr !== 1'b0) begin
         n_fail++; $display("FAIL b2b_gap got rdy=%b wr=%b want 1/0", req_ready, mem_wr);
      end
      tick();
      req_valid = 1'b0;
      if (done === 1'b1) n_done++;
      n_checks++;
      if (mem_wdata !== 32'hA5A5_0F0F || mem_addr !== 32'h34 || mem_wr !== 1'b1) begin
         n_fail++; $display("FAIL b2b_second got addr=%h wdata=%h wr=%b want 00000034/a5a50f0f/1", mem_addr, mem_wdata, mem_wr);
      end
      tick();
      if (done === 1'b1) n_done++;
      n_checks++;
      if (n_done != 2) begin
         n_fail++; $display("FAIL b2b_done_count got %0d want 2", n_done);
      end
   endtask

   task automatic test_reset_abort();
      int n_wr;
      n_wr = 0;
      req_valid = 1'b1; req_addr = 32'h0000_0051; req_data = 32'h0000_0042; req_size = 2'b00;
      tick();
      req_valid = 1'b0;
      tick();
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({done, misalign, mem_rd, mem_wr} !== 4'b0000 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
         n_fail++; $display("FAIL abort_outputs got strobes=%b addr=%h wdata=%h want 0000/0/0", {done, misalign, mem_rd, mem_wr}, mem_addr, mem_wdata);
      end
      n_checks++;
      if (req_ready !== 1'b1) begin
         n_fail++; $display("FAIL abort_ready_in_reset got %b want 1", req_ready);
      end
      tick();
      rst_n = 1'b1;
      mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_DEAD;
      for (int i = 0; i < 3; i++) begin
         tick();
         mem_rvalid = 1'b0;
         if (mem_wr === 1'b1 || done === 1'b1) n_wr++;
      end
      n_checks++;
      if (n_wr != 0 || req_ready !== 1'b1 || mem_wdata !== 32'h0) begin
         n_fail++; $display("FAIL abort_late_rvalid got writes=%0d rdy=%b wdata=%h want 0/1/0", n_wr, req_ready, mem_wdata);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_word();
      test_byte();
      test_half();
      test_misalign();
      test_back_to_back();
      test_reset_abort();
      test_word();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Protocol invariants checked every cycle after reset release.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (mem_rd === 1'b1 && mem_wr === 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL rd_wr_overlap got rd=1 wr=1 want not both");
         end
         if (done === 1'b1 && misalign === 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL done_misalign_overlap got 1/1 want not both");
         end
      end
   end

endmodule
